dpi_stream_sequencer: RTL and testbench
=======================================

Name: dpi_stream_sequencer

Overview:
- Sits directly upstream of the per-regex cancid matcher wrappers.
- Converts a byte-wide packet stream into the matcher control sequence: map flow key to 6-bit stream id, pulse load_state, stream chars, pulse eop once matcher pipeline has drained.
- Holds stream id, new-stream flag and per-stream regex enable mask stable for the whole packet; all wrappers are fanned out from its outputs.

Parameters:
- NUM_STREAMS, 64, stream table entries (power of 2; id width = log2).
- KEY_W, 32, flow key width.
- NUM_REGEX, 16, width of per-stream enable mask.
- LOAD_GAP, 2, idle cycles between load_state and first char_in_vld (covers state restore + input register).
- EOP_DELAY, 4, cycles from last char_in_vld to eop (covers input reg + DFA + output reg).
- DEFAULT_MASK, all ones, enable mask given to newly allocated streams.

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock, synchronous, active-high reset
- in_vld  in  1  upstream byte valid
- in_data  in  8  packet byte
- in_sop  in  1  first byte of packet; in_key valid with it
- in_eop  in  1  last byte of packet (may equal sop byte)
- in_key  in  KEY_W  flow key, sampled on sop
- in_ready  out  1  byte accepted when in_vld & in_ready
- cfg_we  in  1  write enable mask
- cfg_stream  in  6  stream id to configure
- cfg_mask  in  NUM_REGEX  mask value
- char_in  out  8  byte to matchers
- char_in_vld  out  1  char valid
- load_state  out  1  one-cycle pulse, start of packet
- new_stream_id  out  1  stream freshly allocated; valid load_state..eop
- stream_id  out  6  valid load_state..eop
- enable  out  NUM_REGEX  per-regex enable; valid load_state..eop
- eop  out  1  one-cycle pulse, commit packet
- busy  out  1  FSM not in IDLE

Behaviour:
- All outputs registered. Reset: every output 0, FSM to IDLE, all table valid bits cleared, alloc_ptr 0. Reset mid-packet abandons the packet with no eop; upstream is reset with it.
- FSM states: IDLE, LOOKUP, LOAD, GAP, STREAM, DRAIN, EOP.
- IDLE: in_ready=1 only for non-sop bytes, which are dropped (stray data). On in_vld & in_sop, latch in_key without consuming the byte; go to LOOKUP. in_ready is 0 that cycle.
- LOOKUP (1 cycle): parallel compare against valid entries.
  - Hit: stream_id = hit index, new_stream_id=0.
  - Miss: write key at alloc_ptr, set valid, mask entry = DEFAULT_MASK, stream_id = alloc_ptr, new_stream_id=1, alloc_ptr++ (wraps modulo NUM_STREAMS).
  - When the table is full, the miss evicts the entry at alloc_ptr (round-robin).
  - Multiple hits are impossible by construction.
- LOAD: load_state=1 for exactly one cycle; stream_id/new_stream_id/enable already valid that cycle.
- GAP: LOAD_GAP cycles with in_ready=0.
- STREAM: in_ready=1. Each accepted byte appears as char_in/char_in_vld one cycle later; bubbles pass through as char_in_vld=0. The accepted byte with in_eop goes to DRAIN.
- DRAIN: EOP_DELAY-1 cycles after the last char_in_vld, then EOP.
  - eop is asserted exactly EOP_DELAY cycles after the last char_in_vld high.
- EOP: eop=1 for one cycle; then IDLE. Clear new_stream_id/stream_id/enable next cycle. At least one idle cycle is guaranteed between eop and the next load_state.
- A sop byte seen in STREAM is a protocol error: treat it as the eop of the current packet (byte not consumed); the next packet starts from IDLE.
- cfg_we writes the mask table any cycle. When it targets the active stream during a packet, the enable output does not change until the next packet's LOAD (enable latched at LOOKUP). A same-cycle miss-allocation to the same entry overrides cfg (allocation wins).

Optional Feature:
- DPI_SEQ_STATS_EN: adds 32-bit saturating outputs stat_pkts (eops issued), stat_new (allocations), stat_evict (allocations over a valid entry), stat_drop (stray bytes dropped). All are cleared by rst.
- Without the macro, these ports are absent and no counter logic is built.

Decomposition:
- dpi_seq_pkg: STREAM_ID_W, FSM state enum, LOAD_GAP/EOP_DELAY defaults, DEFAULT_MASK.
- Sub-module dpi_stream_cam: key/valid array, parallel compare, hit/index outputs, round-robin alloc_ptr and write port. The mask RAM and FSM stay in the top.

Test Plan:
- Key 0xA5A5_0001, 3-byte packet "abc" after reset -> load_state with stream_id=0, new_stream_id=1, enable=0xFFFF; char_in_vld high 3 cycles, first one 3 cycles after load_state; eop 4 cycles after last char.
- Same key again -> stream_id=0, new_stream_id=0. New key 0x0000_0002 -> stream_id=1, new_stream_id=1.
- 65 distinct keys -> 65th gets stream_id=0, new_stream_id=1. Resending the first key misses (evicted), gets stream_id=1.
- cfg_we stream 0, mask 0x0005 mid-packet on stream 0 -> enable unchanged until eop; next packet on key A shows enable=0x0005.
- Single-byte packet (sop=eop) with in_vld gaps upstream; stray non-sop bytes in IDLE -> one char, eop timing as above, strays dropped (stat_drop increments with DPI_SEQ_STATS_EN).
- rst asserted during STREAM -> next cycle all outputs 0, busy=0, no eop. Previous key re-sent -> new_stream_id=1.

Source files
------------

// File: rtl/dpi_stream_sequencer_pkg.sv
// Shared constants, FSM state encoding and helpers for the DPI stream sequencer.
package dpi_seq_pkg;
   localparam int STREAM_ID_W   = 6;
   localparam int NUM_STREAMS_D = 1 << STREAM_ID_W;
   localparam int KEY_W_D       = 32;
   localparam int NUM_REGEX_D   = 16;
   localparam int LOAD_GAP_D    = 2;
   localparam int EOP_DELAY_D   = 4;
   localparam logic [NUM_REGEX_D-1:0] DEFAULT_MASK_D = '1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOOKUP,
      S_LOAD,
      S_GAP,
      S_STREAM,
      S_DRAIN,
      S_EOP
   } seq_state_t;

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (&v) ? v : v + 32'd1;
   endfunction
endpackage

// File: rtl/dpi_stream_sequencer_if.sv
// Upstream byte-stream handshake into the sequencer (valid/ready, sop/eop, flow key).
interface dpi_stream_sequencer_if
   import dpi_seq_pkg::*;
#(
   parameter int KEY_W = KEY_W_D
);
   logic             in_vld;
   logic [7:0]       in_data;
   logic             in_sop;
   logic             in_eop;
   logic [KEY_W-1:0] in_key;
   logic             in_ready;

   modport master (output in_vld, in_data, in_sop, in_eop, in_key, input in_ready);
   modport slave  (input in_vld, in_data, in_sop, in_eop, in_key, output in_ready);
endinterface

// File: rtl/dpi_stream_cam.sv
// Flow-key CAM: parallel compare over valid entries, round-robin allocation on miss.
// With DPI_SEQ_STATS_EN it also reports whether the allocation slot is occupied.
module dpi_stream_cam
   import dpi_seq_pkg::*;
#(
   parameter int NUM_STREAMS = NUM_STREAMS_D,
   parameter int KEY_W       = KEY_W_D,
   localparam int ID_W       = $clog2(NUM_STREAMS)
)(
   input  logic             clk,
   input  logic             rst,
   input  logic [KEY_W-1:0] key,
   input  logic             lookup,
   output logic             hit,
   output logic [ID_W-1:0]  hit_idx,
   output logic [ID_W-1:0]  alloc_ptr
`ifdef DPI_SEQ_STATS_EN
   ,
   output logic             alloc_valid
`endif
);
   logic [NUM_STREAMS-1:0][KEY_W-1:0] keys;
   logic [NUM_STREAMS-1:0]            valid;
   logic [NUM_STREAMS-1:0]            match;

   for (genvar i = 0; i < NUM_STREAMS; i++) begin : g_cmp
      assign match[i] = valid[i] && (keys[i] == key);
   end

   assign hit = |match;

   // Entries are unique, so OR-ing the indices of set bits yields the hit index.
   always_comb begin
      hit_idx = '0;
      for (int i = 0; i < NUM_STREAMS; i++)
         if (match[i]) hit_idx = hit_idx | ID_W'(i);
   end

`ifdef DPI_SEQ_STATS_EN
   assign alloc_valid = valid[alloc_ptr];
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         valid     <= '0;
         alloc_ptr <= '0;
      end else if (lookup && !hit) begin
         valid[alloc_ptr] <= 1'b1;
         alloc_ptr        <= alloc_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (lookup && !hit) keys[alloc_ptr] <= key;
   end
endmodule

// File: rtl/dpi_stream_sequencer.sv
// Turns a byte packet stream into matcher control: stream lookup, load_state, chars, eop.
// Define DPI_SEQ_STATS_EN to add saturating packet/allocation/eviction/drop counters.
module dpi_stream_sequencer
   import dpi_seq_pkg::*;
#(
   parameter int NUM_STREAMS = NUM_STREAMS_D,
   parameter int KEY_W       = KEY_W_D,
   parameter int NUM_REGEX   = NUM_REGEX_D,
   parameter int LOAD_GAP    = LOAD_GAP_D,
   parameter int EOP_DELAY   = EOP_DELAY_D,
   parameter logic [NUM_REGEX-1:0] DEFAULT_MASK = DEFAULT_MASK_D
)(
   input  logic                           clk,
   input  logic                           rst,
   dpi_stream_sequencer_if.slave          up,
   input  logic                           cfg_we,
   input  logic [$clog2(NUM_STREAMS)-1:0] cfg_stream,
   input  logic [NUM_REGEX-1:0]           cfg_mask,
   output logic [7:0]                     char_in,
   output logic                           char_in_vld,
   output logic                           load_state,
   output logic                           new_stream_id,
   output logic [$clog2(NUM_STREAMS)-1:0] stream_id,
   output logic [NUM_REGEX-1:0]           enable,
   output logic                           eop,
   output logic                           busy
`ifdef DPI_SEQ_STATS_EN
   ,
   output logic [31:0]                    stat_pkts,
   output logic [31:0]                    stat_new,
   output logic [31:0]                    stat_evict,
   output logic [31:0]                    stat_drop
`endif
);
   localparam int ID_W   = $clog2(NUM_STREAMS);
   localparam int STAGES = EOP_DELAY - 1;

   seq_state_t                        state;
   logic                              rdy_q;
   logic                              sop_block;
   logic [KEY_W-1:0]                  key_q;
   logic [7:0]                        gap_cnt;
   logic [STAGES:0]                   vld_pipe;
   logic [NUM_STREAMS-1:0][NUM_REGEX-1:0] mask_mem;

   logic            hit;
   logic [ID_W-1:0] hit_idx;
   logic [ID_W-1:0] alloc_ptr;
   logic            lookup;
   logic            alloc;
   logic            accept;
   logic            sop_err;
   logic            last_pulse;

   // A sop byte is held off in IDLE (key capture only) and after the first byte of a
   // packet; the packet's own sop byte is the first one consumed in STREAM.
   assign up.in_ready = rdy_q & ~(up.in_sop & sop_block);
   assign accept      = up.in_vld & up.in_ready;
   assign lookup      = (state == S_LOOKUP);
   assign alloc       = lookup & ~hit;
   assign sop_err     = (state == S_STREAM) & up.in_vld & up.in_sop & sop_block;
   assign last_pulse  = (state == S_STREAM) & ((accept & up.in_eop) | sop_err);

`ifdef DPI_SEQ_STATS_EN
   logic alloc_valid;
`endif

   dpi_stream_cam #(
      .NUM_STREAMS (NUM_STREAMS),
      .KEY_W       (KEY_W)
   ) u_cam (
      .clk         (clk),
      .rst         (rst),
      .key         (key_q),
      .lookup      (lookup),
      .hit         (hit),
      .hit_idx     (hit_idx),
      .alloc_ptr   (alloc_ptr)
`ifdef DPI_SEQ_STATS_EN
      ,
      .alloc_valid (alloc_valid)
`endif
   );

   // Allocation is ordered last so it overrides a same-cycle cfg write to that entry.
   always_ff @(posedge clk) begin
      if (cfg_we) mask_mem[cfg_stream] <= cfg_mask;
      if (alloc)  mask_mem[alloc_ptr]  <= DEFAULT_MASK;
   end

   // vld_pipe[k] is high k+1 cycles after the last byte was accepted.
   always_ff @(posedge clk) begin
      if (rst) vld_pipe <= '0;
      else     vld_pipe <= (vld_pipe << 1) | EOP_DELAY'(last_pulse);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= S_IDLE;
         rdy_q         <= 1'b0;
         sop_block     <= 1'b1;
         key_q         <= '0;
         gap_cnt       <= '0;
         char_in       <= '0;
         char_in_vld   <= 1'b0;
         load_state    <= 1'b0;
         new_stream_id <= 1'b0;
         stream_id     <= '0;
         enable        <= '0;
         eop           <= 1'b0;
         busy          <= 1'b0;
      end else begin
         load_state  <= 1'b0;
         eop         <= 1'b0;
         char_in_vld <= (state == S_STREAM) & accept;
         if ((state == S_STREAM) && accept) char_in <= up.in_data;
         case (state)
            S_IDLE: begin
               rdy_q     <= 1'b1;
               sop_block <= 1'b1;
               if (up.in_vld && up.in_sop) begin
                  key_q <= up.in_key;
                  rdy_q <= 1'b0;
                  busy  <= 1'b1;
                  state <= S_LOOKUP;
               end
            end
            S_LOOKUP: begin
               load_state <= 1'b1;
               state      <= S_LOAD;
               if (hit) begin
                  stream_id     <= hit_idx;
                  new_stream_id <= 1'b0;
                  enable        <= mask_mem[hit_idx];
               end else begin
                  stream_id     <= alloc_ptr;
                  new_stream_id <= 1'b1;
                  enable        <= DEFAULT_MASK;
               end
            end
            S_LOAD: begin
               gap_cnt <= '0;
               // The input register supplies one of the LOAD_GAP idle cycles itself.
               if (LOAD_GAP <= 1) begin
                  rdy_q     <= 1'b1;
                  sop_block <= 1'b0;
                  state     <= S_STREAM;
               end else begin
                  state <= S_GAP;
               end
            end
            S_GAP: begin
               if (gap_cnt == 8'(LOAD_GAP - 2)) begin
                  rdy_q     <= 1'b1;
                  sop_block <= 1'b0;
                  state     <= S_STREAM;
               end else begin
                  gap_cnt <= gap_cnt + 8'd1;
               end
            end
            S_STREAM: begin
               if (accept) sop_block <= 1'b1;
               if (last_pulse) begin
                  rdy_q <= 1'b0;
                  state <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (vld_pipe[STAGES]) begin
                  eop   <= 1'b1;
                  state <= S_EOP;
               end
            end
            S_EOP: begin
               rdy_q         <= 1'b1;
               busy          <= 1'b0;
               new_stream_id <= 1'b0;
               stream_id     <= '0;
               enable        <= '0;
               state         <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

`ifdef DPI_SEQ_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_pkts  <= '0;
         stat_new   <= '0;
         stat_evict <= '0;
         stat_drop  <= '0;
      end else begin
         if ((state == S_DRAIN) && vld_pipe[STAGES]) stat_pkts <= sat_inc(stat_pkts);
         if (alloc)                                  stat_new  <= sat_inc(stat_new);
         if (alloc && alloc_valid)                   stat_evict <= sat_inc(stat_evict);
         if ((state == S_IDLE) && accept)            stat_drop <= sat_inc(stat_drop);
      end
   end
`endif
endmodule

// File: tb/tb_dpi_stream_sequencer.sv
// Directed self-checking bench for dpi_stream_sequencer (optionally with DPI_SEQ_STATS_EN).
module tb_dpi_stream_sequencer;
   import dpi_seq_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        cfg_we;
   logic [5:0]  cfg_stream;
   logic [15:0] cfg_mask;
   logic [7:0]  char_in;
   logic        char_in_vld;
   logic        load_state;
   logic        new_stream_id;
   logic [5:0]  stream_id;
   logic [15:0] enable;
   logic        eop;
   logic        busy;
`ifdef DPI_SEQ_STATS_EN
   logic [31:0] stat_pkts, stat_new, stat_evict, stat_drop;
`endif

   always #5 clk = ~clk;

   dpi_stream_sequencer_if up_if ();

   dpi_stream_sequencer dut (
      .clk           (clk),
      .rst           (rst),
      .up            (up_if),
      .cfg_we        (cfg_we),
      .cfg_stream    (cfg_stream),
      .cfg_mask      (cfg_mask),
      .char_in       (char_in),
      .char_in_vld   (char_in_vld),
      .load_state    (load_state),
      .new_stream_id (new_stream_id),
      .stream_id     (stream_id),
      .enable        (enable),
      .eop           (eop),
      .busy          (busy)
`ifdef DPI_SEQ_STATS_EN
      ,
      .stat_pkts     (stat_pkts),
      .stat_new      (stat_new),
      .stat_evict    (stat_evict),
      .stat_drop     (stat_drop)
`endif
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // observations captured by the monitor
   int          load_cyc, first_cyc, last_cyc, eop_cyc;
   int          nchar, char_total, eop_cnt, load_cnt;
   logic [5:0]  ld_sid, sid_at_eop;
   logic        ld_new;
   logic [15:0] ld_en, en_at_eop;
   logic [7:0]  chars [8];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (load_state) begin
         load_cyc <= cyc;
         ld_sid   <= stream_id;
         ld_new   <= new_stream_id;
         ld_en    <= enable;
         nchar    <= 0;
         load_cnt <= load_cnt + 1;
      end
      if (char_in_vld) begin
         if (nchar == 0) first_cyc <= cyc;
         last_cyc <= cyc;
         if (nchar < 8) chars[nchar] <= char_in;
         nchar      <= nchar + 1;
         char_total <= char_total + 1;
      end
      if (eop) begin
         eop_cyc    <= cyc;
         eop_cnt    <= eop_cnt + 1;
         en_at_eop  <= enable;
         sid_at_eop <= stream_id;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] d, input logic s, input logic e);
      logic acc;
      int   n;
      up_if.in_vld  = 1'b1;
      up_if.in_data = d;
      up_if.in_sop  = s;
      up_if.in_eop  = e;
      n = 0;
      forever begin
         @(negedge clk);
         acc = up_if.in_ready;
         @(posedge clk);
         #1;
         if (acc) break;
         n++;
         if (n > 60) begin
            total++;
            bad++;
            $error("FAIL send_timeout: byte %0h not accepted in %0d cycles", d, n);
            break;
         end
      end
      up_if.in_vld = 1'b0;
      up_if.in_sop = 1'b0;
      up_if.in_eop = 1'b0;
   endtask

   task automatic send_pkt(input logic [31:0] key, input int len, input logic [7:0] base,
                           input bit gap, input bit do_cfg, input logic [15:0] cm);
      up_if.in_key = key;
      for (int i = 0; i < len; i++) begin
         if (gap && i > 0) tick();
         if (do_cfg && i == 1) begin
            cfg_we     = 1'b1;
            cfg_stream = 6'd0;
            cfg_mask   = cm;
         end
         send_byte(base + 8'(i), i == 0, i == len - 1);
         cfg_we = 1'b0;
      end
   endtask

   task automatic wait_eop(input int prev);
      int n;
      n = 0;
      while (eop_cnt == prev && n < 100) begin
         tick();
         n++;
      end
      if (eop_cnt == prev) begin
         total++;
         bad++;
         $error("FAIL eop_timeout: no eop within %0d cycles", n);
      end
      tick();
      tick();
   endtask

   task automatic pkt(input logic [31:0] key, input int len, input logic [7:0] base,
                      input bit gap, input bit do_cfg, input logic [15:0] cm);
      int prev;
      prev = eop_cnt;
      send_pkt(key, len, base, gap, do_cfg, cm);
      wait_eop(prev);
   endtask

   initial begin
      int prev, ch0;
      rst              = 1'b1;
      cfg_we           = 1'b0;
      cfg_stream       = '0;
      cfg_mask         = '0;
      up_if.in_vld     = 1'b0;
      up_if.in_data    = '0;
      up_if.in_sop     = 1'b0;
      up_if.in_eop     = 1'b0;
      up_if.in_key     = '0;
      tick(); tick(); tick();
      chk("rst_ctl", {load_state, char_in_vld, eop, busy, new_stream_id}, 0);
      chk("rst_sid", stream_id, 0);
      chk("rst_en", enable, 0);
      chk("rst_rdy", up_if.in_ready, 0);
      rst = 1'b0;
      tick();

      // first packet "abc" on a fresh key
      pkt(32'hA5A5_0001, 3, "a", 0, 0, '0);
      chk("p1_sid", ld_sid, 0);
      chk("p1_new", ld_new, 1);
      chk("p1_en", ld_en, 16'hFFFF);
      chk("p1_nchar", nchar, 3);
      chk("p1_data", {chars[0], chars[1], chars[2]}, 24'h616263);
      chk("p1_first_lat", first_cyc - load_cyc, 3);
      chk("p1_eop_lat", eop_cyc - last_cyc, 4);
      chk("p1_sid_eop", sid_at_eop, 0);
      chk("p1_clr", {busy, new_stream_id, stream_id, enable}, 0);

      // hit on same key, then a new key
      pkt(32'hA5A5_0001, 2, "d", 0, 0, '0);
      chk("p2_sid", ld_sid, 0);
      chk("p2_new", ld_new, 0);
      pkt(32'h0000_0002, 2, "f", 0, 0, '0);
      chk("p3_sid", ld_sid, 1);
      chk("p3_new", ld_new, 1);

      // mask write during a packet on stream 0 takes effect on the next packet
      pkt(32'hA5A5_0001, 3, "p", 0, 1, 16'h0005);
      chk("cfg_en_load", ld_en, 16'hFFFF);
      chk("cfg_en_eop", en_at_eop, 16'hFFFF);
      pkt(32'hA5A5_0001, 1, "s", 0, 0, '0);
      chk("cfg_en_next", ld_en, 16'h0005);
      chk("cfg_sid_next", ld_sid, 0);

      // stray bytes in IDLE are dropped
      ch0 = char_total;
      send_byte(8'h11, 0, 0);
      send_byte(8'h22, 0, 0);
      tick();
      chk("stray_nochar", char_total, ch0);
      chk("stray_idle", busy, 0);

      // single-byte packet and a packet with upstream bubbles
      pkt(32'h0000_0003, 1, 8'h5A, 0, 0, '0);
      chk("sb_sid", ld_sid, 2);
      chk("sb_new", ld_new, 1);
      chk("sb_nchar", nchar, 1);
      chk("sb_data", chars[0], 8'h5A);
      chk("sb_first_lat", first_cyc - load_cyc, 3);
      chk("sb_eop_lat", eop_cyc - last_cyc, 4);
      pkt(32'h0000_0002, 3, 8'h30, 1, 0, '0);
      chk("gap_nchar", nchar, 3);
      chk("gap_spread", last_cyc - first_cyc, 4);
      chk("gap_eop_lat", eop_cyc - last_cyc, 4);
      chk("gap_sid", ld_sid, 1);
`ifdef DPI_SEQ_STATS_EN
      chk("st_drop", stat_drop, 2);
      chk("st_pkts", stat_pkts, 7);
      chk("st_new", stat_new, 3);
      chk("st_evict", stat_evict, 0);
`endif

      // fill the table from reset; the 65th key evicts slot 0
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      for (int k = 0; k < 65; k++) begin
         pkt(32'h1000_0000 + 32'(k), 1, 8'h40, 0, 0, '0);
         if (k == 0)  chk("fill_k0_sid", ld_sid, 0);
         if (k == 63) chk("fill_k63_sid", ld_sid, 63);
      end
      chk("fill_k64_sid", ld_sid, 0);
      chk("fill_k64_new", ld_new, 1);
      pkt(32'h1000_0000, 1, 8'h41, 0, 0, '0);
      chk("evicted_sid", ld_sid, 1);
      chk("evicted_new", ld_new, 1);
`ifdef DPI_SEQ_STATS_EN
      chk("st_new_fill", stat_new, 66);
      chk("st_evict_fill", stat_evict, 2);
      chk("st_drop_rst", stat_drop, 0);
`endif

      // reset while streaming abandons the packet
      up_if.in_key = 32'h0000_BEEF;
      send_byte(8'h78, 1, 0);
      send_byte(8'h79, 0, 0);
      chk("mid_busy", busy, 1);
      prev = eop_cnt;
      rst = 1'b1;
      tick();
      chk("mid_rst_ctl", {load_state, char_in_vld, eop, busy, new_stream_id}, 0);
      chk("mid_rst_sid", {stream_id, enable}, 0);
      rst = 1'b0;
      for (int i = 0; i < 10; i++) tick();
      chk("mid_no_eop", eop_cnt, prev);
      pkt(32'h0000_BEEF, 2, 8'h60, 0, 0, '0);
      chk("mid_resend_new", ld_new, 1);
      chk("mid_resend_sid", ld_sid, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
